// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter: bus field widths,
// FSM state encoding and debug owner codes.
package core_mem_arbiter_pkg;

  // Bus field widths, kept in step with the core-wide memory bus definition.
  localparam int MEM_ADDR_R = 64;
  localparam int MEM_DATA_R = 64;
  localparam int MEM_STRB_R = MEM_DATA_R / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

endpackage

// File: rtl/core_mem_arbiter_sel.sv
// Winner selection for the memory arbiter: LSU-first priority, bounded by a
// saturating starvation counter so a waiting fetch is eventually served.
module core_mem_arbiter_sel
  import core_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       imem_req,
  input  logic       dmem_req,
  input  logic [1:0] state,
  input  logic       done_i,
  input  logic       done_d,
  output logic       sel_i,
  output logic       sel_d,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // An owning state freezes the selection; only IDLE arbitrates.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (arb_state_t'(state))
      OWN_I: sel_i = 1'b1;
      OWN_D: sel_d = 1'b1;
      default: begin
        sel_d = dmem_req && (!imem_req || (starve_cnt < LIMIT));
        sel_i = imem_req && !sel_d;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      starve_cnt <= 4'd0;
    end else if (done_i) begin
      starve_cnt <= 4'd0;
    end else if (done_d) begin
      if (!imem_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Two-port arbiter sharing the core memory bus between instruction fetch and
// the LSU. Holds the owner until the fabric grants and routes responses back.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_R,
  parameter int DATA_W       = MEM_DATA_R,
  parameter int STRB_W       = DATA_W / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_gnt,
  output logic              imem_err,
  output logic [DATA_W-1:0] imem_rdata,
  input  logic              dmem_req,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_err,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [STRB_W-1:0] mem_strb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_owner
);

  arb_state_t state;
  arb_state_t state_next;
  logic       sel_i;
  logic       sel_d;
  logic       done_i;
  logic       done_d;
  logic [3:0] starve_cnt;

  assign done_i = mem_gnt && sel_i;
  assign done_d = mem_gnt && sel_d;

  core_mem_arbiter_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .state      (state),
    .done_i     (done_i),
    .done_d     (done_d),
    .sel_i      (sel_i),
    .sel_d      (sel_d),
    .starve_cnt (starve_cnt)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A grant in IDLE completes in place; otherwise the winner takes ownership.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sel_d && !mem_gnt) begin
          state_next = OWN_D;
        end else if (sel_i && !mem_gnt) begin
          state_next = OWN_I;
        end
      end
      OWN_I, OWN_D: begin
        if (mem_gnt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Everything is held at zero while reset is asserted, even mid-transaction.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wen    = 1'b0;
    mem_strb   = '0;
    mem_wdata  = '0;
    imem_gnt   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    dmem_gnt   = 1'b0;
    dmem_err   = 1'b0;
    dmem_rdata = '0;
    arb_owner  = OWNER_NONE;
    if (g_resetn) begin
      if (sel_d) begin
        mem_req   = dmem_req;
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
        arb_owner = OWNER_D;
      end else if (sel_i) begin
        mem_req   = imem_req;
        mem_addr  = imem_addr;
        mem_strb  = '1;
        arb_owner = OWNER_I;
      end
      imem_gnt   = done_i;
      imem_err   = mem_err && sel_i;
      dmem_gnt   = done_d;
      dmem_err   = mem_err && sel_d;
      imem_rdata = mem_rdata;
      dmem_rdata = mem_rdata;
    end
  end

`ifndef SYNTHESIS
  a_imem_req_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state == OWN_I) |-> imem_req);
  a_dmem_req_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state == OWN_D) |-> dmem_req);
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter: fetch, contention,
// wait states, errors, reset mid-transaction and starvation saturation.
module tb_core_mem_arbiter;

  logic        g_clk;
  logic        g_resetn;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_err;
  logic [63:0] imem_rdata;
  logic        dmem_req;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [7:0]  dmem_strb;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_err;
  logic [63:0] dmem_rdata;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;
  logic [1:0]  arb_owner;

  int total;
  int bad;

  core_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STRB_W(8), .STARVE_LIMIT(4)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_err   (imem_err),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_err   (dmem_err),
    .dmem_rdata (dmem_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_err    (mem_err),
    .mem_rdata  (mem_rdata),
    .arb_owner  (arb_owner)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Inputs change just after the falling edge and are checked 1ns later.
  task automatic applyStimulus(input logic ir, input logic [63:0] ia,
                               input logic dr, input logic [63:0] da,
                               input logic dw, input logic [7:0] ds,
                               input logic [63:0] dwd, input logic g,
                               input logic e, input logic [63:0] rd);
    @(negedge g_clk);
    imem_req   = ir;
    imem_addr  = ia;
    dmem_req   = dr;
    dmem_addr  = da;
    dmem_wen   = dw;
    dmem_strb  = ds;
    dmem_wdata = dwd;
    mem_gnt    = g;
    mem_err    = e;
    mem_rdata  = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    g_resetn   = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_strb  = '0;
    dmem_wdata = '0;
    mem_gnt    = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;

    // Reset holds every output low even with requests and a grant present.
    applyStimulus(1, 64'h1000, 1, 64'h2000, 1, 8'hFF, 64'h77, 1, 1, 64'hAA);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_owner", arb_owner, 0);
    checkOutput("rst_dmem_gnt", dmem_gnt, 0);
    checkOutput("rst_imem_rdata", imem_rdata, 0);
    checkOutput("rst_starve", dut.starve_cnt, 0);
    g_resetn = 1'b1;

    // Single-cycle fetch.
    applyStimulus(1, 64'h1000, 0, 0, 0, 0, 0, 1, 0, 64'hDEAD);
    checkOutput("fetch_gnt", imem_gnt, 1);
    checkOutput("fetch_rdata", imem_rdata, 64'hDEAD);
    checkOutput("fetch_addr", mem_addr, 64'h1000);
    checkOutput("fetch_wen", mem_wen, 0);
    checkOutput("fetch_strb", mem_strb, 8'hFF);
    checkOutput("fetch_owner", arb_owner, 2'b01);
    checkOutput("fetch_dgnt", dmem_gnt, 0);

    // Contention with a grant every cycle: D D D D I D D D D I.
    for (int i = 0; i < 10; i++) begin
      logic exp_i;
      exp_i = (i == 4) || (i == 9);
      applyStimulus(1, 64'h1100, 1, 64'h2100, 0, 8'h0F, 0, 1, 0, 64'h1);
      checkOutput($sformatf("cont_ignt_%0d", i), imem_gnt, exp_i);
      checkOutput($sformatf("cont_dgnt_%0d", i), dmem_gnt, !exp_i);
      checkOutput($sformatf("cont_owner_%0d", i), arb_owner, exp_i ? 2'b01 : 2'b10);
    end

    // LSU store with three wait states; fetch arrives during ownership.
    applyStimulus(0, 64'h3000, 1, 64'h2000, 1, 8'h0F, 64'h1234, 0, 0, 0);
    checkOutput("ws_owner0", arb_owner, 2'b10);
    checkOutput("ws_addr0", mem_addr, 64'h2000);
    checkOutput("ws_wen0", mem_wen, 1);
    for (int c = 1; c < 3; c++) begin
      applyStimulus(1, 64'h3000, 1, 64'h2000, 1, 8'h0F, 64'h1234, 0, 0, 0);
      checkOutput($sformatf("ws_owner%0d", c), arb_owner, 2'b10);
      checkOutput($sformatf("ws_addr%0d", c), mem_addr, 64'h2000);
      checkOutput($sformatf("ws_wdata%0d", c), mem_wdata, 64'h1234);
      checkOutput($sformatf("ws_strb%0d", c), mem_strb, 8'h0F);
      checkOutput($sformatf("ws_igrant%0d", c), imem_gnt, 0);
    end
    applyStimulus(1, 64'h3000, 1, 64'h2000, 1, 8'h0F, 64'h1234, 1, 0, 0);
    checkOutput("ws_dgnt3", dmem_gnt, 1);
    checkOutput("ws_ignt3", imem_gnt, 0);
    checkOutput("ws_addr3", mem_addr, 64'h2000);
    applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ws_owner4", arb_owner, 2'b01);
    checkOutput("ws_addr4", mem_addr, 64'h3000);
    checkOutput("ws_wdata4", mem_wdata, 0);
    checkOutput("ws_ignt4", imem_gnt, 0);
    checkOutput("ws_starve4", dut.starve_cnt, 1);
    applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, 1, 0, 64'hBEEF);
    checkOutput("ws_ignt5", imem_gnt, 1);
    checkOutput("ws_rdata5", imem_rdata, 64'hBEEF);

    // LSU load that returns a bus error.
    applyStimulus(0, 0, 1, 64'h4000, 0, 8'hFF, 0, 1, 1, 64'h55);
    checkOutput("err_starve", dut.starve_cnt, 0);
    checkOutput("err_dgnt", dmem_gnt, 1);
    checkOutput("err_derr", dmem_err, 1);
    checkOutput("err_ierr", imem_err, 0);
    checkOutput("err_ignt", imem_gnt, 0);
    checkOutput("err_drdata", dmem_rdata, 64'h55);
    checkOutput("err_irdata", imem_rdata, 64'h55);

    // Reset while the LSU owns the bus with a nonzero starvation count.
    applyStimulus(1, 64'h5000, 1, 64'h6000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("rm_dgnt_a", dmem_gnt, 1);
    applyStimulus(1, 64'h5000, 1, 64'h6000, 0, 8'hFF, 0, 0, 0, 0);
    checkOutput("rm_starve_b", dut.starve_cnt, 1);
    checkOutput("rm_owner_b", arb_owner, 2'b10);
    applyStimulus(1, 64'h5000, 1, 64'h6000, 0, 8'hFF, 0, 0, 0, 0);
    checkOutput("rm_owner_c", arb_owner, 2'b10);
    g_resetn = 1'b0;
    mem_gnt  = 1'b1;
    #1;
    checkOutput("rm_mem_req", mem_req, 0);
    checkOutput("rm_dgnt", dmem_gnt, 0);
    checkOutput("rm_owner", arb_owner, 0);
    checkOutput("rm_starve", dut.starve_cnt, 0);
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, 0, 0, 0, 0);
    g_resetn = 1'b1;
    #1;
    checkOutput("rm_owner_rel", arb_owner, 2'b01);
    checkOutput("rm_mem_req_rel", mem_req, 1);
    checkOutput("rm_addr_rel", mem_addr, 64'h5000);
    checkOutput("rm_starve_rel", dut.starve_cnt, 0);
    applyStimulus(1, 64'h5000, 0, 0, 0, 0, 0, 1, 0, 64'h9);
    checkOutput("rm_ignt", imem_gnt, 1);

    // Ten LSU completions with fetch raised each time; counter saturates.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 64'h7000, 1, 64'h8000, 0, 8'hFF, 0, 0, 0, 0);
      checkOutput($sformatf("sat_pre_%0d", k), dut.starve_cnt, (k - 1 > 4) ? 4 : k - 1);
      applyStimulus(1, 64'h7000, 1, 64'h8000, 0, 8'hFF, 0, 1, 0, 0);
      checkOutput($sformatf("sat_dgnt_%0d", k), dmem_gnt, 1);
    end
    applyStimulus(1, 64'h7000, 1, 64'h8000, 0, 8'hFF, 0, 1, 0, 0);
    checkOutput("sat_peak", dut.starve_cnt, 4);
    checkOutput("sat_ignt", imem_gnt, 1);
    checkOutput("sat_dgnt", dmem_gnt, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_clear", dut.starve_cnt, 0);
    checkOutput("sat_idle_owner", arb_owner, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
